// File: rtl/tmr_fault_manager.sv
// TMR supervisor: localises a single faulty control_module instance, resynchronises it and masks it after repeated failures.
// Optional WAIT_IDLE timeout is compiled in when TMR_MGR_TIMEOUT_EN is defined.
module tmr_fault_manager #(
  parameter int NUM_GROUPS     = 2,
  parameter int PERSIST_CYCLES = 4,
  parameter int RESYNC_CYCLES  = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_GROUPS-1:0] mis_ab_i,
  input  logic [NUM_GROUPS-1:0] mis_bc_i,
  input  logic [NUM_GROUPS-1:0] mis_ac_i,
  input  logic                  busy_i,
  output logic [2:0]            inst_rst_n_o,
  output logic [2:0]            mask_o,
  output logic                  fault_irq_o,
  input  logic [1:0]            reg_addr_i,
  input  logic                  reg_rd_i,
  input  logic                  clr_i,
  output logic [31:0]           reg_rdata_o
);

  localparam int CW = $clog2(PERSIST_CYCLES + RESYNC_CYCLES + SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILTER    = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_RESYNC    = 3'd3,
    ST_SETTLE    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_target;
  logic [3:0]       r_retry;
  logic [2:0]       r_mask;
  logic             r_sticky;
  logic             r_uncorr_q;
  logic             r_irq;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_err_cnt [3];

  logic [2:0]  w_sus;
  logic [2:0]  w_sus_um;
  logic [2:0]  w_tgt_oh;
  logic [1:0]  w_sus_code;
  logic        w_triple;
  logic        w_any_mis;
  logic        w_multi;
  logic        w_single;
  logic        w_uncorr;
  logic        w_confirm;
  logic        w_check;
  logic        w_still;
  logic        w_mask_evt;
  logic        w_timeout;
  logic        w_to_flag;
  logic [31:0] w_status;
  logic [31:0] w_rd_data;

  always_comb begin
    w_sus    = '0;
    w_triple = 1'b0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      w_sus[0] = w_sus[0] | (mis_ab_i[g] & mis_ac_i[g] & ~mis_bc_i[g]);
      w_sus[1] = w_sus[1] | (mis_ab_i[g] & mis_bc_i[g] & ~mis_ac_i[g]);
      w_sus[2] = w_sus[2] | (mis_ac_i[g] & mis_bc_i[g] & ~mis_ab_i[g]);
      w_triple = w_triple | (mis_ab_i[g] & mis_bc_i[g] & mis_ac_i[g]);
    end
  end

  assign w_any_mis = |{mis_ab_i, mis_bc_i, mis_ac_i};
  assign w_sus_um  = w_sus & ~r_mask;
  assign w_multi   = (w_sus_um[0] & w_sus_um[1]) | (w_sus_um[0] & w_sus_um[2]) |
                     (w_sus_um[1] & w_sus_um[2]);
  assign w_single  = (w_sus_um != 3'b000) && !w_multi;
  assign w_sus_code = w_sus_um[0] ? 2'd1 : (w_sus_um[1] ? 2'd2 : (w_sus_um[2] ? 2'd3 : 2'd0));

  // Once a resync is under way, the target's own disturbance must not be mistaken for a new fault.
  assign w_uncorr = (w_multi | w_triple | (|r_mask & w_any_mis)) &&
                    (r_state == ST_IDLE || r_state == ST_FILTER || r_state == ST_WAIT_IDLE);

  always_comb begin
    case (r_target)
      2'd1:    w_tgt_oh = 3'b001;
      2'd2:    w_tgt_oh = 3'b010;
      2'd3:    w_tgt_oh = 3'b100;
      default: w_tgt_oh = 3'b000;
    endcase
  end

  assign w_still    = |(w_sus & w_tgt_oh);
  assign w_mask_evt = w_check && w_still && (r_retry == 4'(MAX_RETRIES - 1));

`ifdef TMR_MGR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_to_flag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else begin
      if (r_state == ST_WAIT_IDLE && busy_i) r_to_cnt <= r_to_cnt + 1'b1;
      else                                   r_to_cnt <= '0;
      if (clr_i)          r_to_flag <= 1'b0;
      else if (w_timeout) r_to_flag <= 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_WAIT_IDLE) && busy_i && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_to_flag = r_to_flag;
`else
  assign w_timeout = 1'b0;
  assign w_to_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_confirm = 1'b0;
    w_check   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_uncorr && w_single) w_next = ST_FILTER;
      end
      ST_FILTER: begin
        if (w_uncorr || !w_single || (w_sus_code != r_target)) begin
          w_next = ST_IDLE;
        end else if (r_cnt == CW'(PERSIST_CYCLES - 1)) begin
          w_next    = ST_WAIT_IDLE;
          w_confirm = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_uncorr)                 w_next = ST_IDLE;
        else if (!busy_i || w_timeout) w_next = ST_RESYNC;
      end
      ST_RESYNC: begin
        if (r_cnt == CW'(RESYNC_CYCLES - 1)) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
          w_check = 1'b1;
          w_next  = (w_still && !w_mask_evt) ? ST_WAIT_IDLE : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    inst_rst_n_o = (r_state == ST_RESYNC) ? ~w_tgt_oh : 3'b111;
    mask_o       = r_mask;
    fault_irq_o  = r_irq;
    reg_rdata_o  = r_rdata;
  end

  always_comb begin
    w_status        = '0;
    w_status[2:0]   = r_mask;
    w_status[3]     = r_sticky;
    w_status[6:4]   = r_state;
    w_status[9:8]   = r_target;
    w_status[15:12] = r_retry;
    w_status[16]    = w_to_flag;
    case (reg_addr_i)
      2'd0:    w_rd_data = w_status;
      2'd1:    w_rd_data = 32'(r_err_cnt[0]);
      2'd2:    w_rd_data = 32'(r_err_cnt[1]);
      default: w_rd_data = 32'(r_err_cnt[2]);
    endcase
  end

  // The phase counter doubles as persist count in FILTER, which starts at one on entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_target   <= '0;
      r_retry    <= '0;
      r_mask     <= '0;
      r_sticky   <= 1'b0;
      r_uncorr_q <= 1'b0;
      r_irq      <= 1'b0;
      r_rdata    <= '0;
      for (int i = 0; i < 3; i++) r_err_cnt[i] <= '0;
    end else begin
      r_uncorr_q <= w_uncorr;
      r_irq      <= (w_uncorr & ~r_uncorr_q) | w_mask_evt;
      if (w_mask_evt) r_mask <= r_mask | w_tgt_oh;

      if (w_next != r_state)      r_cnt <= (w_next == ST_FILTER) ? CW'(1) : '0;
      else if (r_state == ST_FILTER || r_state == ST_RESYNC || r_state == ST_SETTLE)
        r_cnt <= r_cnt + 1'b1;

      if (w_next == ST_IDLE)                         r_target <= 2'd0;
      else if (r_state == ST_IDLE && w_next == ST_FILTER) r_target <= w_sus_code;

      if (w_next == ST_IDLE)        r_retry <= '0;
      else if (w_check && w_still) r_retry <= r_retry + 1'b1;

      if (clr_i)         r_sticky <= 1'b0;
      else if (w_uncorr) r_sticky <= 1'b1;

      for (int i = 0; i < 3; i++) begin
        if (clr_i)
          r_err_cnt[i] <= '0;
        else if (w_confirm && w_tgt_oh[i] && (r_err_cnt[i] != {CNT_W{1'b1}}))
          r_err_cnt[i] <= r_err_cnt[i] + 1'b1;
      end

      if (reg_rd_i) r_rdata <= w_rd_data;
    end
  end

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Directed bench for tmr_fault_manager; counters built 4 bits wide so saturation is reachable quickly.
module tb_tmr_fault_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mis_ab_i, mis_bc_i, mis_ac_i;
  logic        busy_i;
  logic [2:0]  inst_rst_n_o;
  logic [2:0]  mask_o;
  logic        fault_irq_o;
  logic [1:0]  reg_addr_i;
  logic        reg_rd_i;
  logic        clr_i;
  logic [31:0] reg_rdata_o;

  int nAsserts = 0;
  int nFail    = 0;

  tmr_fault_manager #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .mis_ab_i(mis_ab_i), .mis_bc_i(mis_bc_i), .mis_ac_i(mis_ac_i),
    .busy_i(busy_i),
    .inst_rst_n_o(inst_rst_n_o), .mask_o(mask_o), .fault_irq_o(fault_irq_o),
    .reg_addr_i(reg_addr_i), .reg_rd_i(reg_rd_i), .clr_i(clr_i),
    .reg_rdata_o(reg_rdata_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ab, input logic [1:0] bc, input logic [1:0] ac);
    mis_ab_i = ab;
    mis_bc_i = bc;
    mis_ac_i = ac;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
    reg_addr_i = addr;
    reg_rd_i   = 1'b1;
    @(negedge clk);
    reg_rd_i   = 1'b0;
    data       = reg_rdata_o;
  endtask

  // One S1 fault that recovers during SETTLE.
  task automatic recoverableS1();
    applyStimulus(2'b01, 2'b00, 2'b01);
    repeat (4) @(negedge clk);
    applyStimulus(2'b00, 2'b00, 2'b00);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int lowCnt, firstLow, badCnt, pulses, irqCnt;
    logic prevBit;
    logic [31:0] rd;

    rst = 1'b0; busy_i = 1'b0; reg_addr_i = 2'd0; reg_rd_i = 1'b0; clr_i = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    checkOutput("reset_inst_rst_n", 32'(inst_rst_n_o), 32'h7);
    checkOutput("reset_mask", 32'(mask_o), 32'h0);
    checkOutput("reset_irq", 32'(fault_irq_o), 32'h0);
    checkOutput("reset_rdata", reg_rdata_o, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    readReg(2'd0, rd);
    checkOutput("reset_status", rd, 32'h0);

    $display("[TB] S1 confirmed and recovered");
    applyStimulus(2'b01, 2'b00, 2'b01);
    repeat (4) @(negedge clk);
    applyStimulus(2'b00, 2'b00, 2'b00);
    lowCnt = 0; firstLow = 0; badCnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (inst_rst_n_o == 3'b110) begin
        lowCnt++;
        if (firstLow == 0) firstLow = i;
      end else if (inst_rst_n_o != 3'b111) badCnt++;
    end
    checkOutput("s1_first_low_cycle", firstLow, 1);
    checkOutput("s1_low_cycles", lowCnt, 8);
    checkOutput("s1_other_reset_pattern", badCnt, 0);
    readReg(2'd0, rd);
    checkOutput("s1_status_after", rd, 32'h0);
    readReg(2'd1, rd);
    checkOutput("s1_err_cnt1", rd, 32'd1);

    $display("[TB] S1 held only three cycles");
    applyStimulus(2'b01, 2'b00, 2'b01);
    repeat (3) @(negedge clk);
    applyStimulus(2'b00, 2'b00, 2'b00);
    badCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_rst_n_o != 3'b111) badCnt++;
    end
    checkOutput("short_no_resync", badCnt, 0);
    readReg(2'd1, rd);
    checkOutput("short_err_cnt1", rd, 32'd1);

    $display("[TB] S2 confirmed while busy");
    busy_i = 1'b1;
    applyStimulus(2'b01, 2'b01, 2'b00);
    repeat (4) @(negedge clk);
    applyStimulus(2'b00, 2'b00, 2'b00);
    badCnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (inst_rst_n_o != 3'b111) badCnt++;
    end
    checkOutput("busy_no_resync", badCnt, 0);
    readReg(2'd0, rd);
    checkOutput("busy_status_wait_idle", rd, 32'h220);
    checkOutput("busy_inst_before_release", 32'(inst_rst_n_o), 32'h7);
    busy_i = 1'b0;
    @(negedge clk);
    checkOutput("busy_inst_after_release", 32'(inst_rst_n_o), 32'h5);
    lowCnt = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (inst_rst_n_o == 3'b101) lowCnt++;
    end
    checkOutput("busy_low_cycles", lowCnt, 8);
    repeat (20) @(negedge clk);
    readReg(2'd2, rd);
    checkOutput("busy_err_cnt2", rd, 32'd1);

    $display("[TB] S3 persists through three checks");
    applyStimulus(2'b00, 2'b01, 2'b01);
    pulses = 0; irqCnt = 0; prevBit = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (prevBit && !inst_rst_n_o[2]) pulses++;
      prevBit = inst_rst_n_o[2];
      if (fault_irq_o) irqCnt++;
      if (mask_o != 3'b000) applyStimulus(2'b00, 2'b00, 2'b00);
    end
    checkOutput("s3_resync_pulses", pulses, 3);
    checkOutput("s3_irq_pulses", irqCnt, 1);
    checkOutput("s3_mask", 32'(mask_o), 32'h4);
    readReg(2'd0, rd);
    checkOutput("s3_status", rd, 32'h4);
    readReg(2'd3, rd);
    checkOutput("s3_err_cnt3", rd, 32'd1);
    applyStimulus(2'b00, 2'b01, 2'b01);
    badCnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (inst_rst_n_o != 3'b111) badCnt++;
    end
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("s3_masked_no_resync", badCnt, 0);
    checkOutput("s3_mask_kept", 32'(mask_o), 32'h4);
    readReg(2'd3, rd);
    checkOutput("s3_masked_err_cnt3", rd, 32'd1);

    $display("[TB] reset clears mask and aborts resync");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mask_cleared", 32'(mask_o), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(2'b01, 2'b01, 2'b00);
    repeat (4) @(negedge clk);
    applyStimulus(2'b00, 2'b00, 2'b00);
    @(negedge clk);
    checkOutput("abort_in_resync", 32'(inst_rst_n_o), 32'h5);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_released", 32'(inst_rst_n_o), 32'h7);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort_stays_released", 32'(inst_rst_n_o), 32'h7);

    $display("[TB] triple mismatch is uncorrectable");
    applyStimulus(2'b10, 2'b10, 2'b10);
    irqCnt = 0; badCnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fault_irq_o) irqCnt++;
      if (inst_rst_n_o != 3'b111) badCnt++;
    end
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("uncorr_irq_pulses", irqCnt, 1);
    checkOutput("uncorr_no_resync", badCnt, 0);
    readReg(2'd0, rd);
    checkOutput("uncorr_sticky_set", rd, 32'h8);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    readReg(2'd0, rd);
    checkOutput("uncorr_sticky_cleared", rd, 32'h0);

    $display("[TB] counter saturation and clear");
    for (int i = 0; i < 15; i++) recoverableS1();
    readReg(2'd1, rd);
    checkOutput("sat_err_cnt1_full", rd, 32'hF);
    recoverableS1();
    readReg(2'd1, rd);
    checkOutput("sat_err_cnt1_held", rd, 32'hF);
    reg_addr_i = 2'd1; reg_rd_i = 1'b1; clr_i = 1'b1;
    @(negedge clk);
    reg_rd_i = 1'b0; clr_i = 1'b0;
    checkOutput("clr_read_preclear", reg_rdata_o, 32'hF);
    readReg(2'd1, rd);
    checkOutput("clr_read_after", rd, 32'h0);
    applyStimulus(2'b01, 2'b00, 2'b01);
    repeat (3) @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00);
    repeat (30) @(negedge clk);
    readReg(2'd1, rd);
    checkOutput("clr_wins_over_confirm", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
